eth_stream_arbiter: RTL and testbench

Shares the single outgoing AXI-Stream link between the per-channel AXI-to-stream converters (AW, W, AR, R, B). The arbiter grants the link to one converter at a time through that converter's `ready` input and holds the grant for the whole packet (metadata, data, trailer) until the converter's `last` beat. It round-robins between packets, and registers the selected beats into a 2-entry output buffer so that `m_axis_tvalid` never depends on `m_axis_tready`.

---
 rtl/eth_stream_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_eth_stream_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_stream_arbiter.sv
// eth_stream_arbiter
// Shares one outgoing AXI-Stream link between several AXI-to-stream
// converters. A source is granted for a whole packet and keeps the grant
// until its `last` beat is accepted. The next packet is picked round-robin.
// Accepted beats go through a 2-entry buffer, so the m_axis outputs come
// only from registers and never depend on m_axis_tready.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   src_valid           per-source valid
//   src_in_progress     per-source "packet started" flag; holds the grant
//   src_last            per-source end-of-packet flag
//   src_data            per-source beat, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_ready           per-source ready, at most one bit high
//   m_axis_tdata/tvalid/tlast, m_axis_tready   outgoing stream
//   grant_id            index of the currently (or last) granted source
//   busy                high while a source holds the grant
module eth_stream_arbiter #(
    parameter int NUM_SOURCES = 5,
    parameter int DATA_WIDTH  = 128,
    parameter int GRANT_WIDTH = $clog2(NUM_SOURCES)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_SOURCES-1:0]            src_valid,
    input  logic [NUM_SOURCES-1:0]            src_in_progress,
    input  logic [NUM_SOURCES-1:0]            src_last,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] src_data,
    output logic [NUM_SOURCES-1:0]            src_ready,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    output logic [GRANT_WIDTH-1:0]            grant_id,
    output logic                              busy
);

    localparam logic [GRANT_WIDTH-1:0] GRANT_ONE = GRANT_WIDTH'(1);
    localparam logic [GRANT_WIDTH-1:0] LAST_SRC  = GRANT_WIDTH'(NUM_SOURCES - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                     state_r;
    state_t                     next_state_s;
    logic [GRANT_WIDTH-1:0]     grant_id_r;
    logic [GRANT_WIDTH-1:0]     next_grant_s;
    logic [GRANT_WIDTH-1:0]     last_grant_r;
    logic [GRANT_WIDTH-1:0]     next_last_grant_s;

    // Round-robin search
    logic [GRANT_WIDTH-1:0]     start_s;
    logic [2*NUM_SOURCES-1:0]   shifted_s;
    logic [NUM_SOURCES-1:0]     rot_s;
    int                         off_s;
    int                         sum_s;
    logic                       pick_found_s;
    logic [GRANT_WIDTH-1:0]     pick_s;

    // Granted-source view
    logic                       g_valid_s;
    logic                       g_in_progress_s;
    logic                       g_last_s;
    logic [DATA_WIDTH-1:0]      g_data_s;
    logic [NUM_SOURCES-1:0]     ready_s;

    // Output buffer
    logic [1:0]                 count_r;
    logic                       rd_ptr_r;
    logic                       wr_ptr_r;
    logic [DATA_WIDTH-1:0]      mem_data_r [2];
    logic                       mem_last_r [2];
    logic                       buf_full_s;
    logic                       out_valid_s;
    logic                       push_s;
    logic                       pop_s;

    // Round-robin pick: rotate the request vector so bit 0 is last_grant+1,
    // take the lowest set bit, then map the offset back to a source index.
    always_comb begin
        start_s   = (last_grant_r == LAST_SRC) ? '0 : (last_grant_r + GRANT_ONE);
        shifted_s = {src_valid, src_valid} >> start_s;
        rot_s     = shifted_s[NUM_SOURCES-1:0];
        off_s     = 0;
        for (int j = NUM_SOURCES - 1; j >= 0; j--) begin
            if (rot_s[j]) begin
                off_s = j;
            end else begin
                off_s = off_s;
            end
        end
        sum_s = int'(start_s) + off_s;
        if (sum_s >= NUM_SOURCES) begin
            sum_s = sum_s - NUM_SOURCES;
        end else begin
            sum_s = sum_s;
        end
        pick_s       = GRANT_WIDTH'(sum_s);
        pick_found_s = |src_valid;
    end

    assign buf_full_s  = (count_r == 2'd2);
    assign out_valid_s = (count_r != 2'd0);

    // Granted-source mux and ready decode (registered state and count only).
    always_comb begin
        g_valid_s       = 1'b0;
        g_in_progress_s = 1'b0;
        g_last_s        = 1'b0;
        g_data_s        = '0;
        ready_s         = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            g_valid_s       = g_valid_s       | (src_valid[i]       & (grant_id_r == GRANT_WIDTH'(i)));
            g_in_progress_s = g_in_progress_s | (src_in_progress[i] & (grant_id_r == GRANT_WIDTH'(i)));
            g_last_s        = g_last_s        | (src_last[i]        & (grant_id_r == GRANT_WIDTH'(i)));
            g_data_s        = g_data_s | (src_data[i*DATA_WIDTH +: DATA_WIDTH]
                                          & {DATA_WIDTH{grant_id_r == GRANT_WIDTH'(i)}});
            ready_s[i]      = (state_r == ST_LOCKED) && !buf_full_s && (grant_id_r == GRANT_WIDTH'(i));
        end
    end

    assign push_s = (state_r == ST_LOCKED) && !buf_full_s && g_valid_s;
    assign pop_s  = out_valid_s && m_axis_tready;

    // Next-state logic: grant in IDLE, release on accepted last or withdrawal.
    always_comb begin
        next_state_s      = state_r;
        next_grant_s      = grant_id_r;
        next_last_grant_s = last_grant_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    next_state_s = ST_LOCKED;
                    next_grant_s = pick_s;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (push_s && g_last_s) begin
                    next_state_s      = ST_IDLE;
                    next_last_grant_s = grant_id_r;
                end else if (!g_in_progress_s && !g_valid_s) begin
                    // Withdrawn before metadata: nothing was pushed, so the
                    // round-robin pointer stays where it was.
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_LOCKED;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            grant_id_r   <= '0;
            last_grant_r <= LAST_SRC;
        end else begin
            state_r      <= next_state_s;
            grant_id_r   <= next_grant_s;
            last_grant_r <= next_last_grant_s;
        end
    end

    // Two-entry output buffer: storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r  <= 2'd0;
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_data_r[i] <= '0;
                mem_last_r[i] <= 1'b0;
            end
        end else begin
            if (push_s) begin
                mem_data_r[wr_ptr_r] <= g_data_s;
                mem_last_r[wr_ptr_r] <= g_last_s;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign src_ready     = ready_s;
    assign m_axis_tvalid = out_valid_s;
    assign m_axis_tdata  = mem_data_r[rd_ptr_r];
    assign m_axis_tlast  = mem_last_r[rd_ptr_r];
    assign grant_id      = grant_id_r;
    assign busy          = (state_r == ST_LOCKED);

endmodule

// File: tb/tb_eth_stream_arbiter.sv
// Self-checking bench for eth_stream_arbiter: a cycle table for the
// single-source case, then converter models feeding a scoreboard of
// expected beats and expected grant order for the multi-packet cases.
module tb_eth_stream_arbiter;

    localparam int NS = 5;
    localparam int DW = 128;

    logic             clk = 1'b0;
    logic             reset;
    logic [NS-1:0]    src_valid;
    logic [NS-1:0]    src_in_progress;
    logic [NS-1:0]    src_last;
    logic [NS*DW-1:0] src_data;
    logic [NS-1:0]    src_ready;
    logic [DW-1:0]    m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tlast;
    logic             m_axis_tready;
    logic [2:0]       grant_id;
    logic             busy;

    eth_stream_arbiter #(.NUM_SOURCES(NS), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .src_valid(src_valid), .src_in_progress(src_in_progress),
        .src_last(src_last), .src_data(src_data), .src_ready(src_ready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NS-1:0] valid;
        logic [NS-1:0] inprog;
        logic [NS-1:0] last;
        logic [DW-1:0] data;
        logic [NS-1:0] exp_ready;
        logic          exp_tvalid;
        logic          chk_data;
        logic [DW-1:0] exp_tdata;
        logic          exp_tlast;
        logic          exp_busy;
        logic [2:0]    exp_grant;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t   exp_q[$];
    int      exp_g[$];
    int      glog[$];
    int      total = 0;
    int      bad   = 0;

    int      n_pkts[NS];
    int      pkt_len[NS];
    int      pkt_no[NS];
    int      beat_no[NS];
    int      gap_beat[NS];
    int      gap_left[NS];
    int      wd_left[NS];
    logic [NS-1:0] acc;

    function automatic logic [DW-1:0] bd(input int s, input int p, input int b);
        return {32'(s), 32'(p), 32'(b), 32'h5A5A_0001};
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_models();
        for (int i = 0; i < NS; i++) begin
            n_pkts[i] = 0; pkt_len[i] = 0; pkt_no[i] = 0; beat_no[i] = 0;
            gap_beat[i] = 0; gap_left[i] = 0; wd_left[i] = 0;
        end
        acc = '0;
        exp_q.delete(); exp_g.delete(); glog.delete();
        src_valid = '0; src_in_progress = '0; src_last = '0; src_data = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_models();
        m_axis_tready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic push_pkt(input int s, input int p, input int len);
        for (int b = 0; b < len; b++) exp_q.push_back('{bd(s, p, b), (b == len - 1)});
    endtask

    function automatic logic pending();
        logic r = 1'b0;
        for (int i = 0; i < NS; i++) r = r | (pkt_no[i] < n_pkts[i]) | (wd_left[i] > 0);
        return r;
    endfunction

    // Converter model: valid/last/in_progress from packet state, data only on ready&valid.
    task automatic drive_sources();
        logic [NS-1:0]    v;
        logic [NS-1:0]    ip;
        logic [NS-1:0]    l;
        logic [NS*DW-1:0] d;
        v = '0; ip = '0; l = '0; d = '0;
        for (int i = 0; i < NS; i++) begin
            if (wd_left[i] > 0) begin
                v[i] = 1'b1;
            end else if (pkt_no[i] < n_pkts[i]) begin
                ip[i] = (beat_no[i] > 0);
                v[i]  = !(gap_left[i] > 0 && beat_no[i] == gap_beat[i]);
                l[i]  = v[i] && (beat_no[i] == pkt_len[i] - 1);
                if (v[i] && src_ready[i]) d[i*DW +: DW] = bd(i, pkt_no[i], beat_no[i]);
            end
        end
        src_valid = v; src_in_progress = ip; src_last = l; src_data = d;
    endtask

    task automatic sample();
        beat_t e;
        acc = src_ready & src_valid;
        for (int i = 0; i < NS; i++)
            if (acc[i] && beat_no[i] == 0 && wd_left[i] == 0) glog.push_back(i);
        chk("ready_onehot", DW'(src_ready & (src_ready - 5'd1)), '0);
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_beat: got 0x%0h want none", m_axis_tdata);
            end else begin
                e = exp_q.pop_front();
                chk("sb_tdata", m_axis_tdata, e.data);
                chk("sb_tlast", DW'(m_axis_tlast), DW'(e.last));
            end
        end
    endtask

    task automatic advance();
        for (int i = 0; i < NS; i++) begin
            if (acc[i]) begin
                if (beat_no[i] == pkt_len[i] - 1) begin
                    beat_no[i] = 0; pkt_no[i]++;
                end else begin
                    beat_no[i]++;
                end
            end else if (gap_left[i] > 0 && beat_no[i] == gap_beat[i] && pkt_no[i] < n_pkts[i]) begin
                gap_left[i]--;
            end
            if (wd_left[i] > 0) wd_left[i]--;
        end
    endtask

    // One clock: drive after the edge, sample on negedge, update models after next edge.
    task automatic cycle();
        drive_sources();
        @(negedge clk);
        sample();
        @(posedge clk); #1;
        advance();
    endtask

    task automatic run_test(input string nm);
        int n = 0;
        while ((exp_q.size() > 0 || pending()) && n < 500) begin
            cycle();
            n++;
        end
        chk({nm, "_drain"}, DW'(exp_q.size()), '0);
        chk({nm, "_gcount"}, DW'(glog.size()), DW'(exp_g.size()));
        for (int k = 0; k < exp_g.size(); k++)
            chk({nm, "_gorder"}, DW'((k < glog.size()) ? glog[k] : -1), DW'(exp_g[k]));
    endtask

    vec_t vec[6];

    initial begin
        vec[0] = '{5'b00000 | 5'b00100, 5'b00000, 5'b00000, 128'h0, 5'b00000, 1'b0, 1'b1, 128'h0, 1'b0, 1'b0, 3'd0};
        vec[1] = '{5'b00100, 5'b00000, 5'b00000, 128'hA, 5'b00100, 1'b0, 1'b1, 128'h0, 1'b0, 1'b1, 3'd2};
        vec[2] = '{5'b00100, 5'b00100, 5'b00000, 128'hB, 5'b00100, 1'b1, 1'b1, 128'hA, 1'b0, 1'b1, 3'd2};
        vec[3] = '{5'b00100, 5'b00100, 5'b00100, 128'hC, 5'b00100, 1'b1, 1'b1, 128'hB, 1'b0, 1'b1, 3'd2};
        vec[4] = '{5'b00000, 5'b00000, 5'b00000, 128'h0, 5'b00000, 1'b1, 1'b1, 128'hC, 1'b1, 1'b0, 3'd2};
        vec[5] = '{5'b00000, 5'b00000, 5'b00000, 128'h0, 5'b00000, 1'b0, 1'b0, 128'h0, 1'b0, 1'b0, 3'd2};

        reset = 1'b1;
        clear_models();
        m_axis_tready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;

        // Single source, cycle by cycle (row 0 also covers the reset state).
        for (int r = 0; r < 6; r++) begin
            src_valid       = vec[r].valid;
            src_in_progress = vec[r].inprog;
            src_last        = vec[r].last;
            src_data        = '0;
            src_data[2*DW +: DW] = vec[r].data;
            @(negedge clk);
            chk($sformatf("row%0d_ready", r), DW'(src_ready), DW'(vec[r].exp_ready));
            chk($sformatf("row%0d_tvalid", r), DW'(m_axis_tvalid), DW'(vec[r].exp_tvalid));
            chk($sformatf("row%0d_busy", r), DW'(busy), DW'(vec[r].exp_busy));
            chk($sformatf("row%0d_grant", r), DW'(grant_id), DW'(vec[r].exp_grant));
            if (vec[r].chk_data) begin
                chk($sformatf("row%0d_tdata", r), m_axis_tdata, vec[r].exp_tdata);
                chk($sformatf("row%0d_tlast", r), DW'(m_axis_tlast), DW'(vec[r].exp_tlast));
            end
            @(posedge clk); #1;
        end

        // Round-robin between sources 0, 1 and 3.
        do_reset();
        n_pkts[0] = 2; pkt_len[0] = 2;
        n_pkts[1] = 2; pkt_len[1] = 2;
        n_pkts[3] = 1; pkt_len[3] = 2;
        push_pkt(0, 0, 2); push_pkt(1, 0, 2); push_pkt(3, 0, 2);
        push_pkt(0, 1, 2); push_pkt(1, 1, 2);
        exp_g = '{0, 1, 3, 0, 1};
        run_test("rr");

        // Backpressure mid-packet on source 4.
        do_reset();
        n_pkts[4] = 1; pkt_len[4] = 5;
        push_pkt(4, 0, 5);
        exp_g = '{4};
        for (int c = 0; c < 8; c++) begin
            m_axis_tready = !(c >= 3 && c <= 6);
            cycle();
            if (c == 3) begin
                chk("bp_full_ready", DW'(src_ready), '0);
                chk("bp_full_tvalid", DW'(m_axis_tvalid), DW'(1));
            end
            if (c == 6) chk("bp_hold_ready", DW'(src_ready), '0);
            if (c == 7) chk("bp_resume_ready", DW'(src_ready), DW'(5'b10000));
        end
        m_axis_tready = 1'b1;
        run_test("bp");

        // Gap in valid with in_progress held: grant must stay on source 0.
        do_reset();
        n_pkts[0] = 1; pkt_len[0] = 4; gap_beat[0] = 2; gap_left[0] = 3;
        n_pkts[2] = 1; pkt_len[2] = 2;
        push_pkt(0, 0, 4); push_pkt(2, 0, 2);
        exp_g = '{0, 2};
        for (int c = 0; c < 5; c++) begin
            cycle();
            if (c == 3) begin
                chk("gap_grant", DW'(grant_id), DW'(0));
                chk("gap_busy", DW'(busy), DW'(1));
                chk("gap_ready", DW'(src_ready), DW'(5'b00001));
            end
        end
        run_test("gap");

        // Source 1 withdraws before metadata while source 3 waits.
        do_reset();
        wd_left[1] = 1;
        n_pkts[3] = 1; pkt_len[3] = 2;
        push_pkt(3, 0, 2);
        exp_g = '{3};
        for (int c = 0; c < 3; c++) begin
            cycle();
            if (c == 0) chk("wd_grant1", DW'(grant_id), DW'(1));
            if (c == 1) chk("wd_idle", DW'(busy), DW'(0));
            if (c == 2) chk("wd_grant3", DW'(grant_id), DW'(3));
        end
        run_test("wd");

        // Asynchronous reset with two beats buffered.
        do_reset();
        n_pkts[2] = 1; pkt_len[2] = 4;
        m_axis_tready = 1'b0;
        for (int c = 0; c < 3; c++) cycle();
        chk("rst_pre_tvalid", DW'(m_axis_tvalid), DW'(1));
        chk("rst_pre_ready", DW'(src_ready), '0);
        #1 reset = 1'b1;
        #1;
        chk("rst_tvalid", DW'(m_axis_tvalid), '0);
        chk("rst_ready", DW'(src_ready), '0);
        chk("rst_busy", DW'(busy), '0);
        clear_models();
        @(posedge clk); #1;
        reset = 1'b0;
        m_axis_tready = 1'b1;
        n_pkts[0] = 1; pkt_len[0] = 2;
        n_pkts[4] = 1; pkt_len[4] = 2;
        push_pkt(0, 0, 2); push_pkt(4, 0, 2);
        exp_g = '{0, 4};
        run_test("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
